// File: rtl/wb_sched.sv
// wb_sched: register-file writeback sequencer for the multicycle datapath.
// Accepts one writeback command at a time from the main control unit. It waits
// until the selected source is valid (MDR after the load latency, Hi/Lo after
// the mult/div unit drops md_busy). It then drives the MemtoReg select and the
// write address, and pulses reg_write for one cycle.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   cmd_valid   writeback command present
//   cmd_ready   block can accept a command (IDLE only)
//   cmd_src     source code: 0 ALUOut, 1 MDR, 2 Hi, 3 Lo, 4 shift, 5 slt,
//               6 LUI imm, 7 const 227, 8 PC+4; 9..15 illegal
//   cmd_dst     destination register number
//   md_busy     mult/div unit still computing
//   flush       synchronous abort of the pending command
//   mem_to_reg  MemtoReg mux select (latched at acceptance)
//   wr_addr     register-bank write address (latched at acceptance)
//   reg_write   register-bank write enable, one-cycle pulse
//   wb_done     one-cycle pulse when a command retires (write or dst=0)
//   wb_err      one-cycle pulse on illegal source or mult/div timeout
module wb_sched #(
    parameter int unsigned LOAD_LAT   = 2,
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_src,
    input  logic [4:0] cmd_dst,
    input  logic       md_busy,
    input  logic       flush,
    output logic [3:0] mem_to_reg,
    output logic [4:0] wr_addr,
    output logic       reg_write,
    output logic       wb_done,
    output logic       wb_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MEM,
        WAIT_MD,
        WRITE,
        ERR
    } state_t;

    localparam logic [7:0] LOAD_INIT = 8'(LOAD_LAT - 1);
    localparam logic [7:0] MD_LAST   = 8'(MD_TIMEOUT - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] m2r_nx;
    logic [4:0] addr_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        m2r_nx   = mem_to_reg;
        addr_nx  = wr_addr;
        case (state)
            IDLE: begin
                // flush in IDLE blocks acceptance for that edge
                if (cmd_valid && !flush) begin
                    m2r_nx  = cmd_src;
                    addr_nx = cmd_dst;
                    cnt_nx  = '0;
                    case (cmd_src)
                        4'd1: begin
                            state_nx = WAIT_MEM;
                            cnt_nx   = LOAD_INIT;
                        end
                        4'd2, 4'd3:
                            state_nx = WAIT_MD;
                        4'd0, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
                            state_nx = WRITE;
                        default:
                            state_nx = ERR;
                    endcase
                end
            end
            WAIT_MEM: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (cnt == '0) begin
                    state_nx = WRITE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            WAIT_MD: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (!md_busy) begin
                    state_nx = WRITE;
                end else if (cnt == MD_LAST) begin
                    state_nx = ERR;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            WRITE:   state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so each pulse lines up
    // with the cycle spent in the corresponding state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd_ready  <= 1'b1;
            mem_to_reg <= '0;
            wr_addr    <= '0;
            reg_write  <= 1'b0;
            wb_done    <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cmd_ready  <= (state_nx == IDLE);
            mem_to_reg <= m2r_nx;
            wr_addr    <= addr_nx;
            reg_write  <= (state_nx == WRITE) && (addr_nx != '0);
            wb_done    <= (state_nx == WRITE);
            wb_err     <= (state_nx == ERR);
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed, scoreboard-based bench for wb_sched.
// Every expected writeback/error event (pulse pattern, select, address and the
// cycle it must appear in) is queued when stimulus is driven; a negedge monitor
// pops and compares each pulse the DUT produces, and flags unexpected pulses.
module tb_wb_sched;

    localparam int unsigned LOAD_LAT   = 2;
    localparam int unsigned MD_TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_src;
    logic [4:0] cmd_dst;
    logic       md_busy;
    logic       flush;
    logic [3:0] mem_to_reg;
    logic [4:0] wr_addr;
    logic       reg_write;
    logic       wb_done;
    logic       wb_err;

    wb_sched #(
        .LOAD_LAT   (LOAD_LAT),
        .MD_TIMEOUT (MD_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .md_busy    (md_busy),
        .flush      (flush),
        .mem_to_reg (mem_to_reg),
        .wr_addr    (wr_addr),
        .reg_write  (reg_write),
        .wb_done    (wb_done),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    // pulse patterns as {reg_write, wb_done, wb_err}
    localparam logic [2:0] P_WRITE = 3'b110;
    localparam logic [2:0] P_DONE  = 3'b010;
    localparam logic [2:0] P_ERR   = 3'b001;

    typedef struct {
        logic [2:0] pat;
        logic [3:0] m2r;
        logic [4:0] addr;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] p, input logic [3:0] m, input logic [4:0] a, input int c);
        ev_t e;
        e.pat  = p;
        e.m2r  = m;
        e.addr = a;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Present a command one tick after a rising edge; returns the edge number
    // at which it was accepted.
    task automatic issue(input logic [3:0] s, input logic [4:0] d, output int acc);
        chk("ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_src   = s;
        cmd_dst   = d;
        @(posedge clk);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && (reg_write || wb_done || wb_err)) begin
            ev_t e;
            total++;
            assert (exp_q.size() != 0)
            else begin
                bad++;
                $error("FAIL unexpected_pulse observed={rw,done,err}=%b at cycle %0d expected=none",
                       {reg_write, wb_done, wb_err}, cyc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pulse_pattern", 32'({reg_write, wb_done, wb_err}), 32'(e.pat));
                chk("pulse_cycle",   32'(cyc),        32'(e.cyc));
                chk("mem_to_reg",    32'(mem_to_reg), 32'(e.m2r));
                chk("wr_addr",       32'(wr_addr),    32'(e.addr));
            end
        end
    end

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        md_busy   = 1'b0;
        flush     = 1'b0;

        // reset state
        #12;
        chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("rst_mem_to_reg", 32'(mem_to_reg), 32'd0);
        chk("rst_wr_addr",    32'(wr_addr),    32'd0);
        chk("rst_reg_write",  32'(reg_write),  32'd0);
        chk("rst_wb_done",    32'(wb_done),    32'd0);
        chk("rst_wb_err",     32'(wb_err),     32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ALUOut: write in the cycle right after acceptance
        issue(4'd0, 5'd5, acc);
        push(P_WRITE, 4'd0, 5'd5, acc);
        chk("alu_ready_in_write", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("alu_ready_after", 32'(cmd_ready), 32'd1);

        // MDR: LOAD_LAT idle cycles, then write; input changes while busy ignored
        issue(4'd1, 5'd8, acc);
        push(P_WRITE, 4'd1, 5'd8, acc + LOAD_LAT);
        cmd_src = 4'd2;
        cmd_dst = 5'd1;
        repeat (LOAD_LAT + 1) @(posedge clk);
        #1;

        // Lo with md_busy high for 10 cycles
        md_busy = 1'b1;
        issue(4'd3, 5'd9, acc);
        repeat (10) @(posedge clk);
        #1;
        md_busy = 1'b0;
        push(P_WRITE, 4'd3, 5'd9, cyc + 1);
        repeat (2) @(posedge clk);
        #1;

        // Hi with md_busy already low: minimum latency
        issue(4'd2, 5'd4, acc);
        push(P_WRITE, 4'd2, 5'd4, acc + 1);
        repeat (2) @(posedge clk);
        #1;

        // md_busy stuck: timeout error
        md_busy = 1'b1;
        issue(4'd3, 5'd10, acc);
        push(P_ERR, 4'd3, 5'd10, acc + MD_TIMEOUT);
        repeat (MD_TIMEOUT) @(posedge clk);
        #1;
        chk("timeout_ready_in_err", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("timeout_ready_after", 32'(cmd_ready), 32'd1);
        md_busy = 1'b0;

        // illegal source
        issue(4'd12, 5'd6, acc);
        push(P_ERR, 4'd12, 5'd6, acc);
        @(posedge clk);
        #1;

        // constant 227 to r0: done without write
        issue(4'd7, 5'd0, acc);
        push(P_DONE, 4'd7, 5'd0, acc);
        @(posedge clk);
        #1;

        // flush during WAIT_MEM: nothing retires
        issue(4'd1, 5'd11, acc);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ready_after", 32'(cmd_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;

        // flush in IDLE blocks acceptance
        cmd_valid = 1'b1;
        cmd_src   = 4'd0;
        cmd_dst   = 5'd2;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_idle_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // cmd_valid held: accepted every second edge only
        cmd_valid = 1'b1;
        cmd_src   = 4'd0;
        cmd_dst   = 5'd3;
        @(posedge clk);
        #1;
        acc = cyc;
        push(P_WRITE, 4'd0, 5'd3, acc);
        push(P_WRITE, 4'd0, 5'd3, acc + 2);
        chk("b2b_ready_write", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset in the middle of WAIT_MD
        md_busy = 1'b1;
        issue(4'd2, 5'd7, acc);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("arst_mem_to_reg", 32'(mem_to_reg), 32'd0);
        chk("arst_wr_addr",    32'(wr_addr),    32'd0);
        chk("arst_reg_write",  32'(reg_write),  32'd0);
        chk("arst_wb_done",    32'(wb_done),    32'd0);
        chk("arst_wb_err",     32'(wb_err),     32'd0);
        #2;
        reset   = 1'b1;
        md_busy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_ready_later", 32'(cmd_ready), 32'd1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sched.md
Name: wb_sched

Overview:
- Writeback sequencer for the multicycle datapath: accepts one register-file writeback command at a time from the main control unit.
- Waits for the selected source to become valid: memory data after the load latency, Hi/Lo after the mult/div unit finishes.
- Then drives the MemtoReg select, destination register address and a one-cycle RegWrite pulse.
- Sits between the control FSM and the MemtoReg mux / register bank.

Parameters:
- LOAD_LAT, 2, cycles from command acceptance until memory read data (MDR) is valid; legal range 1..15.
- MD_TIMEOUT, 40, maximum cycles spent waiting for md_busy to fall before aborting with error; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  writeback command present.
- cmd_ready  output  1  block can accept a command.
- cmd_src  input  4  source code: 0 ALUOut, 1 MDR, 2 Hi, 3 Lo, 4 shift result, 5 set-less-than, 6 LUI immediate, 7 constant 227, 8 PC+4; 9..15 illegal.
- cmd_dst  input  5  destination register number.
- md_busy  input  1  mult/div unit still computing.
- flush  input  1  synchronous abort of the pending command.
- mem_to_reg  output  4  MemtoReg mux select.
- wr_addr  output  5  register-bank write address.
- reg_write  output  1  register-bank write enable, one-cycle pulse.
- wb_done  output  1  one-cycle pulse when a command retires; retirement by write or by dst=0 suppression.
- wb_err  output  1  one-cycle pulse on illegal source or mult/div timeout.

Behaviour:
- States: IDLE, WAIT_MEM, WAIT_MD, WRITE, ERR. All outputs registered.
- Reset (reset=0, asynchronous):
  - state=IDLE, cmd_ready=1.
  - mem_to_reg=0, wr_addr=0, reg_write=0, wb_done=0, wb_err=0.
  - Wait counter=0.
  - Reset mid-operation abandons the command; no write occurs.
- cmd_ready=1 only in IDLE.
- Acceptance occurs at the edge where cmd_valid&&cmd_ready. cmd_src and cmd_dst are latched at that edge; mem_to_reg and wr_addr update at that edge and hold until the next acceptance.
- Transitions from IDLE on acceptance:
  - src 0,4,5,6,7,8: go to WRITE.
  - src 1: go to WAIT_MEM with counter=LOAD_LAT-1.
  - src 2,3: go to WAIT_MD with counter=0.
  - src 9..15: go to ERR.
- WAIT_MEM: counter decrements each cycle; when counter==0, go to WRITE. With accept at edge k, WRITE is the cycle after edge k+LOAD_LAT.
- WAIT_MD:
  - If md_busy==0 at the edge, go to WRITE.
  - Otherwise counter increments. If counter reaches MD_TIMEOUT-1 with md_busy still 1, go to ERR.
  - md_busy already low at acceptance gives the minimum latency: WRITE one cycle after WAIT_MD.
- WRITE (exactly one cycle):
  - reg_write=1 if latched dst!=0; dst=0 suppresses the write (reg_write=0).
  - wb_done=1 in both cases.
  - Next state IDLE.
- ERR (exactly one cycle): wb_err=1, reg_write=0, wb_done=0; next state IDLE.
- flush=1 at an edge while in WAIT_MEM or WAIT_MD: next state IDLE, no write, no done, no err.
  - flush in IDLE blocks acceptance that edge.
  - flush in WRITE or ERR has no effect; the pulse already issued stands.
- Throughput: at most one command per 2 cycles. cmd_valid held in WRITE/ERR is accepted at the edge returning to IDLE+1; no back-to-back acceptance.
- cmd_src/cmd_dst changes while not accepted are ignored.

Test Plan:
- Reset, then cmd src=0 dst=5 accepted at edge k → cycle after k: reg_write=1, wr_addr=5, mem_to_reg=0, wb_done=1; cmd_ready=0 that cycle, 1 the next.
- src=1 dst=8, LOAD_LAT=2, accepted at edge k → reg_write=0 for 2 cycles, then a single reg_write pulse with mem_to_reg=1, wr_addr=8.
- src=3 dst=9 with md_busy held 1 for 10 cycles then 0 → exactly one reg_write pulse with mem_to_reg=3 on the cycle after the edge sampling md_busy=0; never earlier. Repeat with md_busy stuck 1 → wb_err pulse after MD_TIMEOUT cycles, no reg_write, cmd_ready returns to 1.
- Illegal src=12 → wb_err pulse next cycle, reg_write=0, wb_done=0. src=7 dst=0 → wb_done=1, reg_write=0, mem_to_reg=7.
- src=1 accepted, flush=1 on the following edge → no reg_write/wb_done/wb_err ever; cmd_ready=1 next cycle. Separately, reset asserted asynchronously mid-WAIT_MD → all outputs 0 immediately, cmd_ready=1.
